eth_hdr_insert_64: RTL and testbench
====================================

// Module: eth_hdr_insert_64
// PURPOSE
//  Downstream of the Ethernet arbitration mux. Takes one Ethernet frame (header fields + 64-bit payload
//  stream) and emits a single 64-bit AXI-stream with the 14-byte header prepended. The payload is realigned
//  by a 6-byte offset, so each output beat carries 6 payload bytes from the previous input beat and 2 from
//  the current one. Feeds the MAC TX path at full throughput, with no bubbles between frames.
// PARAMETERS
//  DATA_WIDTH   64  datapath width; only 64 supported
//  KEEP_WIDTH   8   DATA_WIDTH/8
//  USER_WIDTH   1   tuser width; carried on last beat only
// PORTS
//  clk                        in   1   clock
//  rst_n                      in   1   asynchronous active-low reset
//  s_eth_hdr_valid            in   1   header valid
//  s_eth_hdr_ready            out  1   header accepted when valid&ready
//  s_eth_dest_mac             in   48  dest MAC; [47:40] is first byte on wire
//  s_eth_src_mac              in   48  source MAC; [47:40] first
//  s_eth_type                 in   16  ethertype; [15:8] first
//  s_eth_payload_axis_tdata   in   64  payload; byte0=[7:0] first on wire
//  s_eth_payload_axis_tkeep   in   8   byte enables; all-ones except last beat (low-contiguous, >=1 bit)
//  s_eth_payload_axis_tvalid  in   1   payload valid
//  s_eth_payload_axis_tready  out 1   payload ready
//  s_eth_payload_axis_tlast   in   1   last payload beat
//  s_eth_payload_axis_tuser   in   USER_WIDTH  frame status (sampled with tlast)
//  m_axis_tdata/tkeep         out  64/8  output stream data/enables
//  m_axis_tvalid/tready       out/in 1  output handshake
//  m_axis_tlast               out  1   last output beat
//  m_axis_tuser               out  USER_WIDTH  tuser of input last beat, valid on m_axis_tlast
//  busy                       out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all m_axis_* = 0; s_*_ready = 0 during reset; busy = 0; latched fields cleared.
//  Reset asserted mid-frame: partial frame is discarded at once; no further beats are emitted for that frame.
//  Output stage: register plus one-entry skid buffer. m_axis_tready has no combinational path to any
//    s_*_ready. Throughput is 1 beat/clk when m_axis_tready=1. out_rdy = skid buffer empty.
//  Payload must be >=1 beat; zero-length payload is not supported.
//  State machine:
//  - IDLE: s_eth_hdr_ready=out_rdy; payload tready=0.
//    On hdr handshake: latch src[31:0], type; emit beat0 = {src[47:32],dest[47:0]} in byte order
//    (bytes d0..d5,s0,s1), keep=FF, last=0 -> HDR1.
//  - HDR1: payload tready=out_rdy. On beat P (keep K): emit {P bytes0-1, type bytes, src bytes2-5},
//    keep={K[1:0],6'h3F}. Save P bytes2-7 and K[7:2] in residue regs.
//    If tlast && K[7:2]==0: last=1, tuser=in tuser -> IDLE.
//    Else if tlast: latch tuser -> LAST.
//    Else -> PAYLOAD.
//  - PAYLOAD: payload tready=out_rdy. On beat P: emit {P bytes0-1, residue bytes0-5},
//    keep={K[1:0],res_keep}; residue <= P bytes2-7, K[7:2]. Same tlast rules as HDR1.
//  - LAST: payload tready=0. When out_rdy: emit residue, keep={2'b00,res_keep}, last=1, tuser=latched
//    -> IDLE.
//  Byte k of a beat = tdata[8k+7:8k]. Output tkeep is always low-contiguous; non-last beats keep=FF.
//  Back-to-back frames: IDLE accepts the next header on the cycle after the final beat is emitted, so the
//    output stream has no gap between frames.
//  tvalid/tdata are held stable under backpressure until accepted (AXI-stream rules).
// TESTING
//  1. 60-byte payload (8 beats, last keep 0F), tready=1 -> 10 out beats, 74 bytes exact, last keep 03.
//  2. 2-byte payload (1 beat, keep 03) -> 2 out beats, beat1 keep FF, tlast=1; state returns to IDLE.
//  3. 8-byte payload (keep FF, tlast) -> 3 beats, last beat keep 3F with payload bytes 2-7; tuser=1 on input
//     last -> m_axis_tuser=1 only on the final beat.
//  4. m_axis_tready random 50%, 20 frames of lengths 1..64 -> byte-exact output, no drop or duplication,
//     data held stable while stalled.
//  5. Two frames queued back-to-back, tready=1 -> first beat of frame 2 immediately follows tlast of frame 1;
//     busy behaves correctly.
//  6. rst_n pulsed low in the middle of a 40-byte frame -> m_axis_tvalid=0 at once; next frame is emitted
//     correctly with no leftover residue.

Source files
------------

// File: rtl/eth_hdr_insert_64.sv
// Ethernet header inserter: prepends the 14-byte header to a 64-bit payload stream,
// realigning payload by 6 bytes, with a registered output and one-entry skid buffer.
module eth_hdr_insert_64 #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_eth_payload_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR1    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_LAST    = 2'd3
    } state_t;

    // Header fields arrive MSB-first; the stream wants the first wire byte in [7:0].
    function automatic logic [47:0] wire_order48(input logic [47:0] v);
        logic [47:0] r;
        r = 48'h0;
        for (int i = 0; i < 6; i++) begin
            r[8*i +: 8] = v[47-8*i -: 8];
        end
        return r;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [31:0]             src_tail_r;
    logic [15:0]             type_r;
    logic [47:0]             res_data_r;
    logic [5:0]              res_keep_r;
    logic [USER_WIDTH-1:0]   user_r;
    logic                    hdr_ready_r;
    logic                    pay_ready_r;
    logic                    busy_r;

    logic                    emit_s;
    logic [63:0]             beat_data_s;
    logic [7:0]              beat_keep_s;
    logic                    beat_last_s;
    logic [USER_WIDTH-1:0]   beat_user_s;

    logic [63:0]             m_data_r;
    logic [7:0]              m_keep_r;
    logic                    m_valid_r;
    logic                    m_last_r;
    logic [USER_WIDTH-1:0]   m_user_r;
    logic [63:0]             skid_data_r;
    logic [7:0]              skid_keep_r;
    logic                    skid_valid_r;
    logic                    skid_last_r;
    logic [USER_WIDTH-1:0]   skid_user_r;

    logic [47:0]             dest_wire_s;
    logic [47:0]             src_wire_s;
    logic                    hdr_fire_s;
    logic                    pay_fire_s;
    logic                    out_adv_s;
    logic                    skid_nxt_s;
    logic                    pay_tail_empty_s;

    assign dest_wire_s      = wire_order48(s_eth_dest_mac);
    assign src_wire_s       = wire_order48(s_eth_src_mac);
    assign hdr_fire_s       = s_eth_hdr_valid & hdr_ready_r;
    assign pay_fire_s       = s_eth_payload_axis_tvalid & pay_ready_r;
    assign out_adv_s        = ~m_valid_r | m_axis_tready;
    assign skid_nxt_s       = out_adv_s ? 1'b0 : (skid_valid_r | emit_s);
    assign pay_tail_empty_s = (s_eth_payload_axis_tkeep[7:2] == 6'h00);

    // Beat builder and next-state decode.
    always_comb begin
        emit_s      = 1'b0;
        beat_data_s = 64'h0;
        beat_keep_s = 8'h00;
        beat_last_s = 1'b0;
        beat_user_s = {USER_WIDTH{1'b0}};
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hdr_fire_s) begin
                    emit_s      = 1'b1;
                    beat_data_s = {src_wire_s[15:0], dest_wire_s};
                    beat_keep_s = 8'hFF;
                    state_nxt_s = ST_HDR1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR1, ST_PAYLOAD: begin
                if (pay_fire_s) begin
                    emit_s = 1'b1;
                    if (state_r == ST_HDR1) begin
                        beat_data_s = {s_eth_payload_axis_tdata[15:0], type_r[7:0], type_r[15:8], src_tail_r};
                        beat_keep_s = {s_eth_payload_axis_tkeep[1:0], 6'h3F};
                    end else begin
                        beat_data_s = {s_eth_payload_axis_tdata[15:0], res_data_r};
                        beat_keep_s = {s_eth_payload_axis_tkeep[1:0], res_keep_r};
                    end
                    if (s_eth_payload_axis_tlast && pay_tail_empty_s) begin
                        beat_last_s = 1'b1;
                        beat_user_s = s_eth_payload_axis_tuser;
                        state_nxt_s = ST_IDLE;
                    end else if (s_eth_payload_axis_tlast) begin
                        state_nxt_s = ST_LAST;
                    end else begin
                        state_nxt_s = ST_PAYLOAD;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LAST: begin
                if (!skid_valid_r) begin
                    emit_s      = 1'b1;
                    beat_data_s = {16'h0000, res_data_r};
                    beat_keep_s = {2'b00, res_keep_r};
                    beat_last_s = 1'b1;
                    beat_user_s = user_r;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LAST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched header fields, residue and registered ready/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            src_tail_r  <= 32'h0;
            type_r      <= 16'h0;
            res_data_r  <= 48'h0;
            res_keep_r  <= 6'h00;
            user_r      <= {USER_WIDTH{1'b0}};
            hdr_ready_r <= 1'b0;
            pay_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            // Readies follow the skid buffer so m_axis_tready never reaches them combinationally.
            hdr_ready_r <= (state_nxt_s == ST_IDLE) & ~skid_nxt_s;
            pay_ready_r <= ((state_nxt_s == ST_HDR1) | (state_nxt_s == ST_PAYLOAD)) & ~skid_nxt_s;
            if (hdr_fire_s) begin
                src_tail_r <= src_wire_s[47:16];
                type_r     <= s_eth_type;
            end
            if (pay_fire_s) begin
                res_data_r <= s_eth_payload_axis_tdata[63:16];
                res_keep_r <= s_eth_payload_axis_tkeep[7:2];
                if (s_eth_payload_axis_tlast) begin
                    user_r <= s_eth_payload_axis_tuser;
                end
            end
        end
    end

    // Output register with one-entry skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_r     <= 64'h0;
            m_keep_r     <= 8'h00;
            m_valid_r    <= 1'b0;
            m_last_r     <= 1'b0;
            m_user_r     <= {USER_WIDTH{1'b0}};
            skid_data_r  <= 64'h0;
            skid_keep_r  <= 8'h00;
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
            skid_user_r  <= {USER_WIDTH{1'b0}};
        end else if (out_adv_s) begin
            if (skid_valid_r) begin
                m_data_r     <= skid_data_r;
                m_keep_r     <= skid_keep_r;
                m_valid_r    <= 1'b1;
                m_last_r     <= skid_last_r;
                m_user_r     <= skid_user_r;
                skid_valid_r <= 1'b0;
            end else begin
                m_data_r  <= beat_data_s;
                m_keep_r  <= beat_keep_s;
                m_valid_r <= emit_s;
                m_last_r  <= beat_last_s;
                m_user_r  <= beat_user_s;
            end
        end else if (emit_s) begin
            skid_data_r  <= beat_data_s;
            skid_keep_r  <= beat_keep_s;
            skid_valid_r <= 1'b1;
            skid_last_r  <= beat_last_s;
            skid_user_r  <= beat_user_s;
        end
    end

    assign s_eth_hdr_ready           = hdr_ready_r;
    assign s_eth_payload_axis_tready = pay_ready_r;
    assign m_axis_tdata              = m_data_r;
    assign m_axis_tkeep              = m_keep_r;
    assign m_axis_tvalid             = m_valid_r;
    assign m_axis_tlast              = m_last_r;
    assign m_axis_tuser              = m_user_r;
    assign busy                      = busy_r;

endmodule

// File: tb/tb_eth_hdr_insert_64.sv
// Directed bench for eth_hdr_insert_64: hand-computed beats plus a byte-level frame model.
module tb_eth_hdr_insert_64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    logic [47:0] dest = 48'h0;
    logic [47:0] src = 48'h0;
    logic [15:0] etype = 16'h0;
    logic [63:0] p_data = 64'h0;
    logic [7:0]  p_keep = 8'h00;
    logic        p_valid = 1'b0;
    logic        p_ready;
    logic        p_last = 1'b0;
    logic [0:0]  p_user = 1'b0;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [0:0]  m_tuser;
    logic        busy;

    localparam logic [47:0] D = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] S = 48'h101112131415;
    localparam logic [15:0] T = 16'h0800;

    eth_hdr_insert_64 dut (
        .clk(clk), .rst_n(rst_n),
        .s_eth_hdr_valid(hdr_valid), .s_eth_hdr_ready(hdr_ready),
        .s_eth_dest_mac(dest), .s_eth_src_mac(src), .s_eth_type(etype),
        .s_eth_payload_axis_tdata(p_data), .s_eth_payload_axis_tkeep(p_keep),
        .s_eth_payload_axis_tvalid(p_valid), .s_eth_payload_axis_tready(p_ready),
        .s_eth_payload_axis_tlast(p_last), .s_eth_payload_axis_tuser(p_user),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    logic rnd_en = 1'b0;
    int cyc = 0;

    logic [63:0] got_data[$];
    logic [7:0]  got_keep[$];
    logic        got_last[$];
    logic        got_user[$];
    int          got_cyc[$];
    logic [63:0] exp_data[$];
    logic [7:0]  exp_keep[$];
    logic        exp_last[$];
    logic        exp_user[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] keep_mask(input logic [7:0] k);
        logic [63:0] m;
        m = 64'h0;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Output monitor: records accepted beats and checks hold-stability under stall.
    initial begin
        logic        hold;
        logic [63:0] hold_data;
        logic [7:0]  hold_keep;
        logic        hold_last;
        hold = 1'b0;
        hold_data = 64'h0;
        hold_keep = 8'h00;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_valid", 64'(m_tvalid), 64'h1);
                    chk("stall_data", m_tdata, hold_data);
                    chk("stall_keep", 64'(m_tkeep), 64'(hold_keep));
                    chk("stall_last", 64'(m_tlast), 64'(hold_last));
                end
                if (m_tvalid && m_tready) begin
                    got_data.push_back(m_tdata);
                    got_keep.push_back(m_tkeep);
                    got_last.push_back(m_tlast);
                    got_user.push_back(m_tuser[0]);
                    got_cyc.push_back(cyc);
                end
                hold = m_tvalid && !m_tready;
                hold_data = m_tdata;
                hold_keep = m_tkeep;
                hold_last = m_tlast;
            end
        end
    end

    // Sink backpressure: always ready, or a coin flip per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                               input int len, input logic u, input logic [7:0] base);
        logic [7:0]  b[$];
        logic [63:0] dat;
        logic [7:0]  kp;
        int nb;
        for (int i = 0; i < 6; i++) b.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) b.push_back(s[47-8*i -: 8]);
        b.push_back(t[15:8]);
        b.push_back(t[7:0]);
        for (int i = 0; i < len; i++) b.push_back(8'(int'(base) + i));
        nb = (b.size() + 7) / 8;
        for (int j = 0; j < nb; j++) begin
            dat = 64'h0;
            kp = 8'h00;
            for (int k = 0; k < 8; k++) begin
                if (j*8 + k < b.size()) begin
                    dat[8*k +: 8] = b[j*8 + k];
                    kp[k] = 1'b1;
                end
            end
            exp_data.push_back(dat);
            exp_keep.push_back(kp);
            exp_last.push_back(j == nb - 1);
            exp_user.push_back((j == nb - 1) ? u : 1'b0);
        end
    endtask

    task automatic put_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        dest = d; src = s; etype = t; hdr_valid = 1'b1;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = hdr_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("hdr_handshake", 64'(ok), 64'h1);
        hdr_valid = 1'b0;
    endtask

    task automatic put_beat(input logic [63:0] dat, input logic [7:0] kp, input logic lst, input logic u);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        p_data = dat; p_keep = kp; p_last = lst; p_user = u; p_valid = 1'b1;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = p_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("beat_handshake", 64'(ok), 64'h1);
        p_valid = 1'b0;
        p_last = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int len, input logic u, input logic [7:0] base);
        logic [63:0] dat;
        logic [7:0]  kp;
        int nb;
        model_frame(d, s, t, len, u, base);
        put_hdr(d, s, t);
        nb = (len + 7) / 8;
        for (int j = 0; j < nb; j++) begin
            dat = 64'h0;
            kp = 8'h00;
            for (int k = 0; k < 8; k++) begin
                if (j*8 + k < len) begin
                    dat[8*k +: 8] = 8'(int'(base) + j*8 + k);
                    kp[k] = 1'b1;
                end
            end
            put_beat(dat, kp, j == nb - 1, (j == nb - 1) ? u : 1'b0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || m_tvalid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_done", 64'(n < 500), 64'h1);
    endtask

    task automatic compare(input string tag);
        int n;
        chk($sformatf("%s_nbeats", tag), 64'(got_data.size()), 64'(exp_data.size()));
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_data[i] & keep_mask(got_keep[i]), exp_data[i]);
            chk($sformatf("%s_keep%0d", tag, i), 64'(got_keep[i]), 64'(exp_keep[i]));
            chk($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(exp_last[i]));
            chk($sformatf("%s_user%0d", tag, i), 64'(got_user[i]), 64'(exp_user[i]));
        end
        got_data.delete(); got_keep.delete(); got_last.delete(); got_user.delete(); got_cyc.delete();
        exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_user.delete();
    endtask

    initial begin
        int bytes;
        int len;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'h0);
        chk("rst_tdata", m_tdata, 64'h0);
        chk("rst_tkeep", 64'(m_tkeep), 64'h0);
        chk("rst_tlast", 64'(m_tlast), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_hdr_ready", 64'(hdr_ready), 64'h0);
        chk("rst_pay_ready", 64'(p_ready), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_hdr_ready", 64'(hdr_ready), 64'h1);
        chk("idle_pay_ready", 64'(p_ready), 64'h0);

        // 60-byte payload: 74 bytes out in 10 beats, final keep 03
        send_frame(D, S, T, 60, 1'b0, 8'h00);
        drain();
        chk("t1_nbeats", 64'(got_data.size()), 64'd10);
        if (got_data.size() == 10) begin
            chk("t1_beat0", got_data[0], 64'h11100F0E0D0C0B0A);
            chk("t1_lastkeep", 64'(got_keep[9]), 64'h03);
            chk("t1_last9", 64'(got_last[9]), 64'h1);
        end
        bytes = 0;
        foreach (got_keep[i]) bytes += $countones(got_keep[i]);
        chk("t1_bytes", 64'(bytes), 64'd74);
        compare("t1");

        // 2-byte payload, busy tracked through the frame
        model_frame(D, S, T, 2, 1'b0, 8'hAA);
        put_hdr(D, S, T);
        chk("t2_busy_hi", 64'(busy), 64'h1);
        put_beat(64'h000000000000ABAA, 8'h03, 1'b1, 1'b0);
        drain();
        chk("t2_busy_lo", 64'(busy), 64'h0);
        chk("t2_nbeats", 64'(got_data.size()), 64'd2);
        if (got_data.size() == 2) begin
            chk("t2_beat1", got_data[1], 64'hABAA000815141312);
            chk("t2_keep1", 64'(got_keep[1]), 64'hFF);
            chk("t2_last1", 64'(got_last[1]), 64'h1);
        end
        compare("t2");

        // 8-byte payload with tuser: residue beat keep 3F, tuser only on last
        send_frame(D, S, T, 8, 1'b1, 8'h40);
        drain();
        chk("t3_nbeats", 64'(got_data.size()), 64'd3);
        if (got_data.size() == 3) begin
            chk("t3_beat2", got_data[2], 64'h0000474645444342);
            chk("t3_keep2", 64'(got_keep[2]), 64'h3F);
            chk("t3_user0", 64'(got_user[0]), 64'h0);
            chk("t3_user1", 64'(got_user[1]), 64'h0);
            chk("t3_user2", 64'(got_user[2]), 64'h1);
        end
        compare("t3");

        // 20 frames, random lengths, random sink backpressure
        rnd_en = 1'b1;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 64);
            send_frame(D ^ 48'(f), S + 48'(f), T + 16'(f), len, 1'(f), 8'(f * 16));
        end
        drain();
        rnd_en = 1'b0;
        compare("t4");
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back frames: no gap between tlast of A and first beat of B
        send_frame(D, S, T, 16, 1'b0, 8'h10);
        send_frame(S, D, 16'h86DD, 9, 1'b1, 8'h80);
        drain();
        chk("t5_nbeats", 64'(got_data.size()), 64'd7);
        if (got_data.size() == 7) begin
            chk("t5_a_last", 64'(got_last[3]), 64'h1);
            chk("t5_gap", 64'(got_cyc[4] - got_cyc[3]), 64'd1);
            chk("t5_span", 64'(got_cyc[6] - got_cyc[0]), 64'd6);
        end
        compare("t5");

        // Reset mid-frame, then a clean frame with no stale residue
        put_hdr(D, S, T);
        put_beat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
        put_beat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(m_tvalid), 64'h0);
        chk("t6_rst_busy", 64'(busy), 64'h0);
        chk("t6_rst_hdr_ready", 64'(hdr_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        got_data.delete(); got_keep.delete(); got_last.delete(); got_user.delete(); got_cyc.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(D, S, T, 10, 1'b1, 8'hC0);
        drain();
        compare("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
